// File: rtl/final_project_soc_sysid_ext.sv
// System-identification Avalon-MM slave: build ID/timestamp, free-running uptime
// with a tear-free hi/lo snapshot, scratch, capability and control registers.
module final_project_soc_sysid_ext #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          ADDR_W       = 3,
    parameter int          READ_LATENCY = 1,
    parameter int          UPTIME_W     = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    typedef enum logic [7:0] {
        REG_ID      = 8'd0,
        REG_TS      = 8'd1,
        REG_UP_LO   = 8'd2,
        REG_UP_HI   = 8'd3,
        REG_SCRATCH = 8'd4,
        REG_CAPS    = 8'd5,
        REG_CTRL    = 8'd6
    } reg_addr_e;

    localparam logic [31:0] CAPS_WORD =
        {16'h0000, 4'(ADDR_W), 4'(READ_LATENCY), 8'(UPTIME_W)};

    logic [7:0]          addr8;
    logic [UPTIME_W-1:0] uptime;
    logic [63:0]         uptime_ext;
    logic [31:0]         shadow;
    logic [31:0]         scratch;
    logic                freeze;
    logic [31:0]         rd_mux;

    logic wr_scratch;
    logic wr_ctrl;
    logic ctrl_clear;
    logic rd_up_lo;

    logic [READ_LATENCY-1:0]       pipe_valid;
    logic [READ_LATENCY-1:0][31:0] pipe_data;

    assign addr8      = 8'(address);
    assign uptime_ext = 64'(uptime);

    assign wr_scratch = write && (addr8 == REG_SCRATCH);
    assign wr_ctrl    = write && (addr8 == REG_CTRL) && byteenable[0];
    assign ctrl_clear = wr_ctrl && writedata[1];
    assign rd_up_lo   = read && (addr8 == REG_UP_LO);

    // Read mux sees pre-edge register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0; // NOTE: default assigned first so no path through the case infers a latch
        case (addr8)
            REG_ID:      rd_mux = SYSTEM_ID;
            REG_TS:      rd_mux = TIMESTAMP;
            REG_UP_LO:   rd_mux = uptime_ext[31:0];
            REG_UP_HI:   rd_mux = shadow;
            REG_SCRATCH: rd_mux = scratch;
            REG_CAPS:    rd_mux = CAPS_WORD;
            REG_CTRL:    rd_mux = {31'b0, freeze};
            default:     rd_mux = '0;
        endcase
    end

    // Clear wins over FREEZE and increment; counter wraps naturally at UPTIME_W bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            uptime <= '0; // NOTE: non-blocking for all sequential state so every flop samples pre-edge values
        end else if (ctrl_clear) begin
            uptime <= '0;
        end else if (!freeze) begin
            uptime <= uptime + UPTIME_W'(1);
        end
    end

    // Reading UP_LO latches the upper half so a following UP_HI read is coherent.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow <= '0;
        end else if (rd_up_lo) begin
            shadow <= uptime_ext[63:32];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= '0;
        end else if (wr_scratch) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) begin
                    scratch[8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

    // A CLEAR write is a command: it zeroes the counter without touching FREEZE,
    // so software can reset a frozen counter and keep it frozen.
    always_ff @(posedge clock) begin
        if (reset) begin
            freeze <= 1'b0;
        end else if (wr_ctrl && !writedata[1]) begin
            freeze <= writedata[0];
        end
    end

    // Fixed-latency read pipeline; data stages only load on a valid slot, so the
    // last stage naturally holds the most recent returned word.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: pipeline data is reset too, so readdata is defined as 0 out of reset
            pipe_valid <= '0;
            pipe_data  <= '0;
        end else begin
            pipe_valid[0] <= read;
            if (read) begin
                pipe_data[0] <= rd_mux;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign readdata      = pipe_data[READ_LATENCY-1];
    assign readdatavalid = pipe_valid[READ_LATENCY-1];

endmodule
